// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the 74138 scan sequencer.
//   state_e      : sequencer states (IDLE, BLANK, DWELL)
//   ENABLES_ON   : {G1,/G2A,/G2B} value that enables the decoder
//   ENABLES_OFF  : {G1,/G2A,/G2B} value that blanks every decoder output
package decoder_scan_pkg;

  localparam int unsigned NUM_CHAN = 8;
  localparam int unsigned CHAN_W   = 3;

  localparam logic [2:0] ENABLES_ON  = 3'b100;
  localparam logic [2:0] ENABLES_OFF = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan requester and decoder_scan_ctrl.
// Optional macro: DECODER_SCAN_MASK_EN adds mask_i (1 = skip channel).
//   slave  : the sequencer (inputs start/stop/single/dwell[/mask], outputs selects, enables, status)
//   master : the requester (mirror of slave)
interface decoder_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 16
);
  logic               start_i;
  logic               stop_i;
  logic               single_i;
  logic [DWELL_W-1:0] dwell_i;
`ifdef DECODER_SCAN_MASK_EN
  logic [7:0]         mask_i;
`endif
  logic               select_a_o;
  logic               select_b_o;
  logic               select_c_o;
  logic               g1_en_o;
  logic               g2a_en_n_o;
  logic               g2b_en_n_o;
  logic [2:0]         chan_o;
  logic               step_o;
  logic               frame_done_o;
  logic               busy_o;

  modport slave (
`ifdef DECODER_SCAN_MASK_EN
    input  mask_i,
`endif
    input  start_i, stop_i, single_i, dwell_i,
    output select_a_o, select_b_o, select_c_o,
    output g1_en_o, g2a_en_n_o, g2b_en_n_o,
    output chan_o, step_o, frame_done_o, busy_o
  );

  modport master (
`ifdef DECODER_SCAN_MASK_EN
    output mask_i,
`endif
    output start_i, stop_i, single_i, dwell_i,
    input  select_a_o, select_b_o, select_c_o,
    input  g1_en_o, g2a_en_n_o, g2b_en_n_o,
    input  chan_o, step_o, frame_done_o, busy_o
  );

endinterface

// File: rtl/scan_chan_pick.sv
// Cyclic search for the next unmasked channel, plus the highest unmasked
// channel (the frame-final one). Purely combinational.
//   mask_i       : 1 = channel skipped
//   cur_i        : current channel
//   incl_cur_i   : 1 = search starts at cur_i itself, 0 = at cur_i+1
//   next_chan_c  : first unmasked channel found going upward with wrap
//   next_ok_c    : at least one channel unmasked
//   final_chan_c : highest unmasked channel
module scan_chan_pick
  import decoder_scan_pkg::*;
(
  input  logic [7:0]        mask_i,
  input  logic [CHAN_W-1:0] cur_i,
  input  logic              incl_cur_i,
  output logic [CHAN_W-1:0] next_chan_c,
  output logic              next_ok_c,
  output logic [CHAN_W-1:0] final_chan_c
);

  logic [CHAN_W-1:0] start_idx;
  logic [CHAN_W-1:0] idx;

  // Walk offsets high-to-low so the nearest unmasked channel wins.
  always_comb begin
    next_chan_c = '0;
    next_ok_c   = 1'b0;
    idx         = '0;
    start_idx   = incl_cur_i ? cur_i : CHAN_W'(cur_i + CHAN_W'(1));
    for (int k = NUM_CHAN - 1; k >= 0; k--) begin
      idx = CHAN_W'(start_idx + CHAN_W'(k));
      if (!mask_i[idx]) begin
        next_chan_c = idx;
        next_ok_c   = 1'b1;
      end
    end
  end

  // Highest unmasked index; meaningless when next_ok_c is 0.
  always_comb begin
    final_chan_c = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (!mask_i[i]) final_chan_c = CHAN_W'(i);
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Break-before-make scan sequencer driving a 74138's C/B/A selects and
// G1,/G2A,/G2B enables so that exactly one decoder output is low at a time.
// Optional macro: DECODER_SCAN_MASK_EN (per-channel skip mask via bus.mask_i).
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : decoder_scan_ctrl_if.slave (start/stop/single/dwell in,
//                  selects, enables, chan, step, frame_done, busy out)
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DWELL_W      = 16,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  decoder_scan_ctrl_if.slave  bus
);

  localparam int unsigned BLANK_W  = 8;
  localparam logic [BLANK_W-1:0] BLANK_M1 = BLANK_W'(BLANK_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic                single_q, single_d;
  logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [2:0]          en_q, en_d;
  logic                step_q, step_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  logic [CHAN_W-1:0]   pick_chan;
  logic                pick_ok;
  logic [CHAN_W-1:0]   final_chan;

`ifdef DECODER_SCAN_MASK_EN
  // In IDLE chan_q is 0, so an inclusive search yields the first channel.
  scan_chan_pick u_pick (
    .mask_i       (bus.mask_i),
    .cur_i        (chan_q),
    .incl_cur_i   (state_q == IDLE),
    .next_chan_c  (pick_chan),
    .next_ok_c    (pick_ok),
    .final_chan_c (final_chan)
  );
`else
  assign pick_chan  = (state_q == IDLE) ? '0 : CHAN_W'(chan_q + CHAN_W'(1));
  assign pick_ok    = 1'b1;
  assign final_chan = CHAN_W'(NUM_CHAN - 1);
`endif

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    single_d    = single_q;
    blank_cnt_d = blank_cnt_q;
    dwell_cnt_d = dwell_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.stop_i && pick_ok) begin
          state_d     = BLANK;
          chan_d      = pick_chan;
          single_d    = bus.single_i;
          blank_cnt_d = BLANK_M1;
        end
      end
      BLANK: begin
        if (bus.stop_i) begin
          state_d = IDLE;
          chan_d  = '0;
        end else if (blank_cnt_q == '0) begin
          state_d     = DWELL;
          // Zero dwell behaves as one cycle.
          dwell_cnt_d = (bus.dwell_i == '0) ? '0 : DWELL_W'(bus.dwell_i - 1'b1);
        end else begin
          blank_cnt_d = BLANK_W'(blank_cnt_q - 1'b1);
        end
      end
      DWELL: begin
        if (bus.stop_i) begin
          state_d = IDLE;
          chan_d  = '0;
        end else if (dwell_cnt_q == '0) begin
          if (!pick_ok || (single_q && chan_q == final_chan)) begin
            state_d = IDLE;
            chan_d  = '0;
          end else begin
            state_d     = BLANK;
            chan_d      = pick_chan;
            blank_cnt_d = BLANK_M1;
          end
        end else begin
          dwell_cnt_d = DWELL_W'(dwell_cnt_q - 1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        chan_d  = '0;
      end
    endcase

    en_d         = (state_d == DWELL) ? ENABLES_ON : ENABLES_OFF;
    step_d       = (state_q == BLANK) && (state_d == DWELL);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DWELL) && (dwell_cnt_d == '0) &&
                   pick_ok && (chan_d == final_chan);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      chan_q       <= '0;
      single_q     <= 1'b0;
      blank_cnt_q  <= '0;
      dwell_cnt_q  <= '0;
      en_q         <= ENABLES_OFF;
      step_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      single_q     <= single_d;
      blank_cnt_q  <= blank_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      en_q         <= en_d;
      step_q       <= step_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.select_a_o   = chan_q[0];
  assign bus.select_b_o   = chan_q[1];
  assign bus.select_c_o   = chan_q[2];
  assign bus.g1_en_o      = en_q[2];
  assign bus.g2a_en_n_o   = en_q[1];
  assign bus.g2b_en_n_o   = en_q[0];
  assign bus.chan_o       = chan_q;
  assign bus.step_o       = step_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.busy_o       = busy_q;

endmodule
